// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner_pkg : key codes and matrix position-to-code lookup   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package keypad_scanner_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_STAR = 4'hA;
  localparam key_code_t KEY_HASH = 4'hB;
  localparam key_code_t KEY_NONE = 4'hF;

  // Layout: r0 1 2 3 | r1 4 5 6 | r2 7 8 9 | r3 * 0 #
  function automatic key_code_t key_at(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'b0000: code = 4'd1;
      4'b0001: code = 4'd2;
      4'b0010: code = 4'd3;
      4'b0100: code = 4'd4;
      4'b0101: code = 4'd5;
      4'b0110: code = 4'd6;
      4'b1000: code = 4'd7;
      4'b1001: code = 4'd8;
      4'b1010: code = 4'd9;
      4'b1100: code = KEY_STAR;
      4'b1101: code = 4'd0;
      4'b1110: code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer, resets to all ones (idle pins)    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner : 4x3 matrix scan, frame decode, debounce, outputs   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       key_strobe
);

  localparam int SLOT_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int STABLE_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(SCAN_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(DEBOUNCE_FRAMES);

  logic [2:0] col_s;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [3:0]          row_n_q, row_n_d;
  logic [1:0]          hits_q, hits_d;
  key_code_t           frame_key_q, frame_key_d;
  key_code_t           cand_q, cand_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  key_code_t           accepted_q, accepted_d;
  logic                new_key_q, new_key_d;
  logic [9:0]          keypad_q, keypad_d;
  logic                startn_q, startn_d;
  logic                stopn_q, stopn_d;
  logic                strobe_q, strobe_d;

  logic       slot_last, frame_end;
  logic [1:0] row_hits, hits_total;
  logic [2:0] hits_sum;
  key_code_t  row_key, key_total, frame_code;

  sync_2ff #(.WIDTH(3)) u_col_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (col_n),
    .dout   (col_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q      <= '0;
      row_idx_q   <= 2'd0;
      row_n_q     <= 4'b1110;
      hits_q      <= 2'd0;
      frame_key_q <= KEY_NONE;
      cand_q      <= KEY_NONE;
      stable_q    <= '0;
      accepted_q  <= KEY_NONE;
      new_key_q   <= 1'b0;
      keypad_q    <= '0;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      row_idx_q   <= row_idx_d;
      row_n_q     <= row_n_d;
      hits_q      <= hits_d;
      frame_key_q <= frame_key_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      accepted_q  <= accepted_d;
      new_key_q   <= new_key_d;
      keypad_q    <= keypad_d;
      startn_q    <= startn_d;
      stopn_q     <= stopn_d;
      strobe_q    <= strobe_d;
    end
  end

  // Scan timing and per-frame accumulation; hit count saturates at 2 (= reject)
  always_comb begin
    slot_last = (slot_q == SLOT_LAST);
    frame_end = slot_last && (row_idx_q == 2'd3);
    row_hits  = 2'd0;
    row_key   = KEY_NONE;
    for (int c = 0; c < 3; c++) begin
      if (!col_s[c]) begin
        row_key  = key_at(row_idx_q, 2'(c));
        row_hits = (row_hits == 2'd2) ? 2'd2 : row_hits + 2'd1;
      end
    end
    hits_sum   = {1'b0, hits_q} + {1'b0, row_hits};
    hits_total = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
    key_total  = (hits_q == 2'd0) ? row_key : frame_key_q;
    frame_code = (hits_total == 2'd1) ? key_total : KEY_NONE;

    slot_d      = slot_last ? '0 : slot_q + SLOT_W'(1);
    row_idx_d   = slot_last ? row_idx_q + 2'd1 : row_idx_q;
    row_n_d     = ~(4'b0001 << row_idx_d);
    hits_d      = hits_q;
    frame_key_d = frame_key_q;
    if (slot_last) begin
      hits_d      = frame_end ? 2'd0 : hits_total;
      frame_key_d = frame_end ? KEY_NONE : key_total;
    end
  end

  always_comb begin
    cand_d     = cand_q;
    stable_d   = stable_q;
    accepted_d = accepted_q;
    new_key_d  = 1'b0;
    if (frame_end) begin
      if (frame_code == cand_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + STABLE_W'(1);
      end else begin
        cand_d   = frame_code;
        stable_d = STABLE_W'(1);
      end
      if ((stable_d == STABLE_MAX) && (cand_d != accepted_q)) begin
        accepted_d = cand_d;
        new_key_d  = (cand_d != KEY_NONE);
      end
    end
  end

  always_comb begin
    keypad_d = '0;
    if (accepted_q <= 4'd9) keypad_d = 10'(1) << accepted_q;
    startn_d = (accepted_q != KEY_STAR);
    stopn_d  = (accepted_q != KEY_HASH);
    strobe_d = new_key_q;
  end

  assign row_n      = row_n_q;
  assign keypad     = keypad_q;
  assign startn     = startn_q;
  assign stopn      = stopn_q;
  assign key_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scanner : directed vectors, SCAN_CYCLES=4, 3-frame debounce|
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic       startn, stopn, key_strobe;

  // Pressed keys, bit index = row*3 + col
  logic [11:0] mask;
  int cyc;
  int tests;
  int fails;
  int strobe_cnt = 0;
  int base;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .col_n      (col_n),
    .row_n      (row_n),
    .keypad     (keypad),
    .startn     (startn),
    .stopn      (stopn),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (mask[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clk) if (key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;

  typedef struct {
    int          cyc;
    logic [11:0] mask_after;
    logic [3:0]  row;   // 0 = not checked
    logic [9:0]  kp;
    logic        sn;
    logic        pn;
    logic        stb;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_out(input string tag, input logic [9:0] kp, input logic sn,
                           input logic pn, input logic stb);
    check({tag, "_keypad"}, 32'(keypad), 32'(kp));
    check({tag, "_startn"}, 32'(startn), 32'(sn));
    check({tag, "_stopn"},  32'(stopn),  32'(pn));
    check({tag, "_strobe"}, 32'(key_strobe), 32'(stb));
  endtask

  task automatic do_reset(input logic [11:0] m);
    resetn = 1'b0;
    mask   = m;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
  endtask

  // Edge n = nth rising edge after reset release; sample 1 time unit after it
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    if (n > 0) #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    mask   = '0;
    cyc    = 0;

    // Reset, row rotation, '5' press/hold/release
    vecs[0]  = '{0,   12'h010, 4'b1110, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3,   12'h010, 4'b1110, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4,   12'h010, 4'b1101, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8,   12'h010, 4'b1011, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{12,  12'h010, 4'b0111, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16,  12'h010, 4'b1110, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{48,  12'h010, 4'b0000, 10'h000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{49,  12'h010, 4'b0000, 10'h020, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{50,  12'h010, 4'b0000, 10'h020, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{80,  12'h000, 4'b0000, 10'h020, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{128, 12'h000, 4'b0000, 10'h020, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{129, 12'h000, 4'b0000, 10'h000, 1'b1, 1'b1, 1'b0};

    do_reset(12'h010);
    base = strobe_cnt;
    for (int i = 0; i < NV; i++) begin
      goto(vecs[i].cyc);
      if (vecs[i].row != 4'b0000)
        check($sformatf("v%0d_row_n", i), 32'(row_n), 32'(vecs[i].row));
      check_out($sformatf("v%0d", i), vecs[i].kp, vecs[i].sn, vecs[i].pn, vecs[i].stb);
      mask = vecs[i].mask_after;
    end
    goto(140);
    check("press5_strobe_count", 32'(strobe_cnt - base), 32'd1);

    // Bounce on '8': only frames 3..5 see it stable, so acceptance at edge 80
    do_reset(12'h000);
    base = strobe_cnt;
    for (int c = 0; c < 32; c++) begin
      goto(c);
      mask = (((c / 5) % 2) == 0) ? 12'h080 : 12'h000;
    end
    goto(32);
    mask = 12'h080;
    goto(65); check_out("bounce_e65", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(80); check_out("bounce_e80", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(81); check_out("bounce_e81", 10'h100, 1'b1, 1'b1, 1'b1);
    goto(82); check_out("bounce_e82", 10'h100, 1'b1, 1'b1, 1'b0);
    goto(96);
    check("bounce_strobe_count", 32'(strobe_cnt - base), 32'd1);

    // '*' then a direct switch to '#'
    do_reset(12'h200);
    base = strobe_cnt;
    goto(48);  check_out("star_e48", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(49);  check_out("star_e49", 10'h000, 1'b0, 1'b1, 1'b1);
    goto(64);  mask = 12'h800;
    goto(112); check_out("hash_e112", 10'h000, 1'b0, 1'b1, 1'b0);
    goto(113); check_out("hash_e113", 10'h000, 1'b1, 1'b0, 1'b1);
    goto(114); check_out("hash_e114", 10'h000, 1'b1, 1'b0, 1'b0);
    goto(120);
    check("special_strobe_count", 32'(strobe_cnt - base), 32'd2);

    // '1' and '9' together: rejected as multi-press
    do_reset(12'h101);
    base = strobe_cnt;
    goto(49); check_out("multi_e49", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(65); check_out("multi_e65", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(80); check_out("multi_e80", 10'h000, 1'b1, 1'b1, 1'b0);
    mask = 12'h000;
    goto(160);
    check("multi_strobe_count", 32'(strobe_cnt - base), 32'd0);

    // Reset during frame 2 of a '3' press, then again while '3' is accepted
    do_reset(12'h004);
    base = strobe_cnt;
    goto(24);
    resetn = 1'b0;
    #1;
    check("midrst_row_n", 32'(row_n), 32'h0000000E);
    check_out("midrst", 10'h000, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
    goto(33); check_out("rst3_e33", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(48); check_out("rst3_e48", 10'h000, 1'b1, 1'b1, 1'b0);
    goto(49); check_out("rst3_e49", 10'h008, 1'b1, 1'b1, 1'b1);
    goto(55);
    resetn = 1'b0;
    #1;
    check_out("rst3_async", 10'h000, 1'b1, 1'b1, 1'b0);
    check("rst3_strobe_count", 32'(strobe_cnt - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
